// File: rtl/piso_shift_register.sv
// piso_shift_register: parallel-in, serial-out transmitter, LSB first.
// A WIDTH-bit word is accepted through a valid/ready handshake and shifted
// out one bit per clock with shift_en=1. done pulses for one cycle after the
// final bit's shift edge.
// Optional feature macro: PISO_PRELOAD_EN -- when defined, the next word may
// be accepted on the last bit's shift edge so words stream with no idle bit.
module piso_shift_register #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg, sreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             done_nxt;
   logic             last_edge;
   logic             preload_ok;
   logic             accept;

   // the coming edge shifts out the final bit of the current word
   assign last_edge = (state == SHIFT) && shift_en && (cnt == CW'(1));

`ifdef PISO_PRELOAD_EN
   assign preload_ok = last_edge;
`else
   assign preload_ok = 1'b0;
`endif

   // ready depends only on state, cnt, shift_en and rst_n (never on load_valid)
   assign load_ready = rst_n && ((state == IDLE) || preload_ok);
   assign accept     = load_valid && load_ready;

   // line idles low; in SHIFT the current bit is the LSB of sreg
   assign serial_out = (state == SHIFT) ? sreg[0] : 1'b0;
   assign busy       = (state == SHIFT);

   // next-state logic: load on accept, shift on enabled edges, finish on last bit
   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               sreg_nxt  = load_data;
               cnt_nxt   = CW'(WIDTH);
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en) begin
               sreg_nxt = sreg >> 1;
               cnt_nxt  = cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
                  // accept only possible here with preload enabled
                  if (accept) begin
                     sreg_nxt  = load_data;
                     cnt_nxt   = CW'(WIDTH);
                     state_nxt = SHIFT;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         sreg  <= sreg_nxt;
         cnt   <= cnt_nxt;
         done  <= done_nxt;
      end
   end

endmodule

// File: tb/tb_piso_shift_register.sv
// Testbench for piso_shift_register (WIDTH=4): table-driven directed vectors,
// hand-written corner sequences, then randomized stimulus against a
// queue-based model of the bits still to be transmitted.
module tb_piso_shift_register;

`ifdef PISO_PRELOAD_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       load_valid;
   logic [3:0] load_data;
   logic       load_ready;
   logic       shift_en;
   logic       serial_out;
   logic       busy;
   logic       done;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       rst_n;
      logic       lv;
      logic [3:0] d;
      logic       sh;
      logic       er;
      logic       eb;
      logic       es;
      logic       ed;
   } vec_t;

   vec_t tbl[$];

   // model: bits of the word in flight still to appear, LSB first
   bit   mq[$];
   logic mdone;

   piso_shift_register #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .shift_en   (shift_en),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check1(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
      end
   endtask

   // drive one cycle's inputs, check outputs mid-cycle, then take the edge
   task automatic cyc(input logic r, input logic lv, input logic [3:0] d, input logic sh,
                      input logic er, input logic eb, input logic es, input logic ed);
      rst_n = r; load_valid = lv; load_data = d; shift_en = sh;
      #1;
      check1("load_ready", load_ready, er);
      check1("busy", busy, eb);
      check1("serial_out", serial_out, es);
      check1("done", done, ed);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; load_valid = 1'b0; load_data = '0; shift_en = 1'b0;
      @(posedge clk);
      #1;

      // basic transmit of 4'b1011, then stall sequence with 4'h6
      //                rst lv d     sh  rdy  bsy ser done
      tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, PRE,  1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b1, PRE,  1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < tbl.size(); i++)
         cyc(tbl[i].rst_n, tbl[i].lv, tbl[i].d, tbl[i].sh,
             tbl[i].er, tbl[i].eb, tbl[i].es, tbl[i].ed);

      // busy rejection: 4'hF offered during 4'h9, taken in the next IDLE cycle
      cyc(1, 1, 4'h9, 1, 1, 0, 0, 0);
      cyc(1, 1, 4'hF, 1, 0, 1, 1, 0);
      cyc(1, 1, 4'hF, 1, 0, 1, 0, 0);
      cyc(1, 1, 4'hF, 1, 0, 1, 0, 0);
      cyc(1, 0, 4'hF, 1, PRE, 1, 1, 0);
      cyc(1, 1, 4'hF, 1, 1, 0, 0, 1);
      cyc(1, 0, 4'h0, 0, 0, 1, 1, 0);

      // reset mid-word: abort 4'hF after two shifts, no done afterwards
      cyc(0, 0, 4'h0, 0, 0, 1, 1, 0);
      cyc(1, 1, 4'hF, 1, 1, 0, 0, 0);
      cyc(1, 0, 4'h0, 1, 0, 1, 1, 0);
      cyc(1, 0, 4'h0, 1, 0, 1, 1, 0);
      cyc(0, 0, 4'h0, 1, 0, 1, 1, 0);
      cyc(1, 0, 4'h0, 1, 1, 0, 0, 0);
      cyc(1, 0, 4'h0, 1, 1, 0, 0, 0);
      cyc(1, 0, 4'h0, 1, 1, 0, 0, 0);

      // back-to-back words 4'hA then 4'h5 with load_valid held
      cyc(1, 1, 4'hA, 1, 1, 0, 0, 0);
      cyc(1, 1, 4'h5, 1, 0, 1, 0, 0);
      cyc(1, 1, 4'h5, 1, 0, 1, 1, 0);
      cyc(1, 1, 4'h5, 1, 0, 1, 0, 0);
`ifdef PISO_PRELOAD_EN
      cyc(1, 1, 4'h5, 1, 1, 1, 1, 0);
      cyc(1, 0, 4'h0, 1, 0, 1, 1, 1);
`else
      cyc(1, 1, 4'h5, 1, 0, 1, 1, 0);
      cyc(1, 1, 4'h5, 1, 1, 0, 0, 1);
      cyc(1, 0, 4'h0, 1, 0, 1, 1, 0);
`endif
      cyc(1, 0, 4'h0, 1, 0, 1, 0, 0);
      cyc(1, 0, 4'h0, 1, 0, 1, 1, 0);
      cyc(1, 0, 4'h0, 1, PRE, 1, 0, 0);
      cyc(1, 0, 4'h0, 1, 1, 0, 0, 1);
      cyc(0, 0, 4'h0, 0, 0, 0, 0, 0);

      // randomized traffic against the queue model
      mq.delete();
      mdone = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         logic       r, lv, sh, er, eb, es;
         logic [3:0] d;
         logic       nd;
         r  = ($urandom_range(0, 63) != 0);
         lv = 1'($urandom_range(0, 1));
         sh = ($urandom_range(0, 3) != 0);
         d  = 4'($urandom);
         eb = (mq.size() > 0);
         es = eb ? mq[0] : 1'b0;
         er = r && (mq.size() == 0 || (PRE && mq.size() == 1 && sh));
         cyc(r, lv, d, sh, er, eb, es, mdone);
         if (!r) begin
            mq.delete();
            mdone = 1'b0;
         end else begin
            nd = 1'b0;
            if (mq.size() > 0 && sh) begin
               void'(mq.pop_front());
               if (mq.size() == 0) nd = 1'b1;
            end
            if (lv && er) begin
               mq.delete();
               for (int b = 0; b < 4; b++) mq.push_back(d[b]);
            end
            mdone = nd;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
